sha2_msg_padder: RTL

//  Autonomous SHA-2 message-block builder. Accepts packets over a valid/ready handshake and

---
 rtl/sha2_msg_padder.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sha2_msg_padder.sv
// SHA-2 message padder: packs packets into BLK_W-bit blocks,
// appends 0x80, zero fill and big-endian bit length.
// Ports:
//   clk, rst_b (async, active-high), clr (sync clear)
//   in_data/in_valid/in_last/in_nbytes/in_ready : packet in
//   blk/blk_valid/blk_last/blk_ready           : block out
module sha2_msg_padder #(
  parameter int PKT_W = 64,
  parameter int BLK_W = 512,
  parameter int LEN_W = 64,
  localparam int NB_W = $clog2(PKT_W/8) + 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clr,
  input  logic [PKT_W-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [NB_W-1:0]  in_nbytes,
  output logic             in_ready,
  output logic [BLK_W-1:0] blk,
  output logic             blk_valid,
  output logic             blk_last,
  input  logic             blk_ready
);

  localparam int CNT    = BLK_W / PKT_W;
  localparam int IDX_W  = $clog2(CNT);
  localparam int NBYTES = PKT_W / 8;

  localparam logic [IDX_W-1:0] LEN_IDX =
    IDX_W'(CNT - LEN_W / PKT_W);
  localparam logic [IDX_W-1:0] END_IDX =
    IDX_W'(CNT - 1);
  localparam logic [PKT_W-1:0] PAD_WORD =
    {8'h80, {(PKT_W-8){1'b0}}};

  typedef enum logic [2:0] {
    S_FILL,
    S_PAD,
    S_ZERO,
    S_LEN,
    S_EMIT
  } st_t;

  st_t              r_st;
  st_t              r_ret;
  logic [IDX_W-1:0] r_idx;
  logic [LEN_W-1:0] r_len;
  logic [BLK_W-1:0] r_blk;
  logic             r_bv;
  logic             r_bl;

  st_t              w_nx;
  st_t              w_st_d;
  st_t              w_ret_d;
  logic [IDX_W-1:0] w_idx_d;
  logic [LEN_W-1:0] w_len_d;
  logic             w_bv_d;
  logic             w_bl_d;
  logic             w_we;
  logic [PKT_W-1:0] w_wdata;
  logic             w_fin;
  logic             w_hs;
  logic             w_at_end;
  logic             w_wrap;
  logic             w_full;
  logic [PKT_W-1:0] w_tail;
  logic [LEN_W-1:0] w_len_sh;
  logic [PKT_W-1:0] w_len_word;

  assign w_at_end = (r_idx == END_IDX);
  assign w_full   = int'(in_nbytes) >= NBYTES;

  // Length words go out MS-first, one per slot
  // from LEN_IDX onward.
  assign w_len_sh =
    r_len << (int'(r_idx - LEN_IDX) * PKT_W);
  assign w_len_word = w_len_sh[LEN_W-1 -: PKT_W];

  // Tail word: keep bytes 0..n-1, 0x80 at byte n.
  always_comb begin
    w_tail = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (b < int'(in_nbytes))
        w_tail[PKT_W-1-8*b -: 8] =
          in_data[PKT_W-1-8*b -: 8];
      else if (b == int'(in_nbytes))
        w_tail[PKT_W-1-8*b -: 8] = 8'h80;
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_wdata = '0;
    w_nx    = r_st;
    w_len_d = r_len;
    w_fin   = 1'b0;
    w_hs    = 1'b0;
    unique case (r_st)
      S_FILL: begin
        if (in_valid) begin
          w_we = 1'b1;
          if (!in_last) begin
            w_wdata = in_data;
            w_len_d = r_len + LEN_W'(PKT_W);
          end else if (w_full) begin
            w_wdata = in_data;
            w_len_d = r_len + LEN_W'(PKT_W);
            w_nx    = S_PAD;
          end else begin
            w_wdata = w_tail;
            w_len_d = r_len +
              (LEN_W'(in_nbytes) << 3);
            w_nx    = S_ZERO;
          end
        end
      end
      S_PAD: begin
        w_we    = 1'b1;
        w_wdata = PAD_WORD;
        w_nx    = S_ZERO;
      end
      S_ZERO: begin
        if (r_idx == LEN_IDX) w_nx = S_LEN;
        else                  w_we = 1'b1;
      end
      S_LEN: begin
        w_we    = 1'b1;
        w_wdata = w_len_word;
        if (w_at_end) begin
          w_fin = 1'b1;
          w_nx  = S_FILL;
        end
      end
      S_EMIT: begin
        if (blk_ready) begin
          w_hs = 1'b1;
          // Message finished: restart the count.
          if (r_bl && r_ret == S_FILL)
            w_len_d = '0;
        end
      end
      default: ;
    endcase
  end

  // A write into the last slot closes the block;
  // the pending state is parked in r_ret.
  assign w_wrap = w_we & w_at_end;

  always_comb begin
    w_st_d  = w_nx;
    w_ret_d = r_ret;
    w_idx_d = r_idx;
    w_bv_d  = r_bv;
    w_bl_d  = r_bl;
    if (w_we)
      w_idx_d = w_at_end ? '0 : r_idx + IDX_W'(1);
    if (w_wrap) begin
      w_st_d  = S_EMIT;
      w_ret_d = w_nx;
      w_bv_d  = 1'b1;
      w_bl_d  = w_fin;
    end else if (w_hs) begin
      w_st_d  = r_ret;
      w_bv_d  = 1'b0;
      w_bl_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_st  <= S_FILL;
      r_ret <= S_FILL;
      r_idx <= '0;
      r_len <= '0;
      r_blk <= '0;
      r_bv  <= 1'b0;
      r_bl  <= 1'b0;
    end else if (clr) begin
      r_st  <= S_FILL;
      r_ret <= S_FILL;
      r_idx <= '0;
      r_len <= '0;
      r_blk <= '0;
      r_bv  <= 1'b0;
      r_bl  <= 1'b0;
    end else begin
      r_st  <= w_st_d;
      r_ret <= w_ret_d;
      r_idx <= w_idx_d;
      r_len <= w_len_d;
      r_bv  <= w_bv_d;
      r_bl  <= w_bl_d;
      if (w_we)
        r_blk[BLK_W-1-int'(r_idx)*PKT_W -: PKT_W]
          <= w_wdata;
    end
  end

  assign in_ready  = (r_st == S_FILL);
  assign blk       = r_blk;
  assign blk_valid = r_bv;
  assign blk_last  = r_bl;

endmodule
